display_sequencer: RTL
======================

// Module: display_sequencer
// PURPOSE
//  Game-screen controller: FSM (title/play/win/lose) that enables and prioritises the back/char/coin/message RGB layers.
//  Feeds the VGA output pins. Times message screens in frames, counted from vsync.
//  Replaces plain OR-merging with a registered priority compositor.
// PARAMETERS
//  COIN_GOAL    8    coins collected to enter WIN (1..2^CNT_W-1)
//  CNT_W        4    coin_count width
//  MSG_FRAMES   120  frame ticks WIN/LOSE message is held before returning to IDLE (1..2^FRM_W)
//  BLINK_FRAMES 30   frame ticks per blink half-period in IDLE (BLINK_EN only; 1..2^FRM_W)
//  FRM_W        8    frame/blink counter width
// PORTS
//  clk         in   1      pixel clock
//  rst_n       in   1      async active-low reset
//  vsync       in   1      VGA vsync, active-low pulse
//  video_on    in   1      high in visible area
//  start       in   1      synchronised start button, level
//  coin_hit    in   1      one-cycle pulse per coin collected
//  hazard_hit  in   1      one-cycle pulse, character hit
//  r/g/b_back  in   1 each background layer pixel
//  r/g/b_char  in   1 each character layer pixel
//  r/g/b_coin  in   1 each coin layer pixel
//  r/g/b_mess  in   1 each message layer pixel
//  r/g/b_buf   out  1 each composited pixel, registered
//  state       out  2      current FSM state
//  coin_count  out  CNT_W  coins collected this game
//  msg_sel     out  2      message ROM select: 0 title, 1 win, 2 lose, 3 none
// BEHAVIOUR
//  Reset (async): state=IDLE, coin_count=0, r/g/b_buf=0, msg_sel=0, frame_cnt=0, blink_on=1, vsync_d=1.
//  Frame tick: tick = vsync & ~vsync_d (vsync rising edge, end of sync pulse); one clk wide.
//  FSM (state encoding IDLE=0, PLAY=1, WIN=2, LOSE=3); all transitions on clk edge:
//   IDLE: msg_sel=0; layers back+mess. start=1 -> PLAY, coin_count<=0.
//   PLAY: msg_sel=3; layers back+char+coin, mess masked.
//         hazard_hit -> LOSE (wins over coin_hit in same cycle; count not incremented).
//         coin_hit: coin_count+1; if new value==COIN_GOAL -> WIN same edge. Count saturates at COIN_GOAL.
//   WIN/LOSE: msg_sel=1/2; layers back+mess. frame_cnt<=0 on entry.
//         Each tick increments; tick with frame_cnt==MSG_FRAMES-1 -> IDLE. start, coin_hit, hazard_hit ignored.
//   Entry to IDLE: frame_cnt<=0, blink_on<=1. coin_count holds last game's value until next start.
//  Compositor: a layer is present when any of its enabled rgb bits is 1.
//   Priority mess > char > coin > back; output = highest present layer's rgb, else 000.
//   video_on=0 forces 000. Latency 1 clk: inputs at edge N -> r/g/b_buf at edge N+1.
//   Layer enables use the state registered at edge N.
//  Reset mid-frame: outputs drop to 0 immediately; first tick after release needs a full low->high vsync.
// CONFIGURATION
//  BLINK_EN defined: in IDLE, mess layer enabled only while blink_on=1.
//   Each tick increments frame_cnt; tick with frame_cnt==BLINK_FRAMES-1 toggles blink_on, frame_cnt<=0.
//  BLINK_EN undefined: blink_on held at 1 (IDLE message solid). IDLE frame_cnt holds 0. No blink logic synthesised.
// STRUCTURE
//  Package display_pkg: state encodings, MSG_* select constants, layer priority index constants.
//  Sub-module layer_compositor: enables[3:0] + 4 RGB triplets + video_on -> registered rgb.
//   Holds the pipeline register and priority mux. FSM, counters and tick detect live in the top.
// TESTING
//  1 Reset with all layers=111, video_on=1 -> rgb_buf=000, state=0, msg_sel=0; first edge after release -> rgb=mess.
//  2 IDLE, start pulse; char=100, coin=010, back=001 -> state=1, msg_sel=3.
//    Next-cycle rgb=100; char=000 -> 010; video_on=0 -> 000.
//  3 PLAY, 8 coin_hit pulses (COIN_GOAL=8) -> coin_count=8, state=2 on the 8th edge, msg_sel=1.
//    120 ticks later -> state=0, msg_sel=0.
//  4 PLAY at coin_count=7, coin_hit and hazard_hit same cycle -> state=3, coin_count stays 7.
//  5 BLINK_EN, IDLE, mess=111 every pixel -> rgb alternates 111 / back every 30 ticks.
//    Without BLINK_EN -> constant 111.
//  6 WIN with frame_cnt=60, assert rst_n=0 mid-line -> immediate rgb=000, state=0, coin_count=0.

Source files
------------

// File: rtl/display_pkg.sv
//------------------------------------------------------------------------------
// display_pkg
// Shared definitions for the game-screen display sequencer:
//   - FSM state encoding (IDLE/PLAY/WIN/LOSE)
//   - message ROM select codes
//   - layer index constants, which also set compositor priority (higher wins)
//   - helper mapping a state to its message select
//------------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } state_t;

    localparam logic [1:0] MSG_TITLE = 2'd0;
    localparam logic [1:0] MSG_WIN   = 2'd1;
    localparam logic [1:0] MSG_LOSE  = 2'd2;
    localparam logic [1:0] MSG_NONE  = 2'd3;

    // Layer indices into the enables vector; a larger index has priority.
    localparam int LAYER_BACK = 0;
    localparam int LAYER_COIN = 1;
    localparam int LAYER_CHAR = 2;
    localparam int LAYER_MESS = 3;
    localparam int NUM_LAYERS = 4;

    function automatic logic [1:0] msg_for_state(input state_t s);
        logic [1:0] sel;
        case (s)
            ST_IDLE: sel = MSG_TITLE;
            ST_PLAY: sel = MSG_NONE;
            ST_WIN:  sel = MSG_WIN;
            default: sel = MSG_LOSE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/layer_compositor.sv
//------------------------------------------------------------------------------
// layer_compositor
// Registered priority compositor for four 3-bit RGB layers.
// A layer is present when it is enabled and any of its rgb bits is 1.
// Priority mess > char > coin > back; nothing present gives 000.
// video_on=0 forces 000. One clock of latency.
// Ports:
//   clk, rst_n        pixel clock, async active-low reset (output cleared)
//   video_on          visible-area flag
//   enables[3:0]      per-layer enable, indexed by display_pkg LAYER_* constants
//   rgb_back/coin/char/mess  {r,g,b} of each layer
//   rgb               registered composited pixel {r,g,b}
//------------------------------------------------------------------------------
module layer_compositor
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       video_on,
    input  logic [3:0] enables,
    input  logic [2:0] rgb_back,
    input  logic [2:0] rgb_coin,
    input  logic [2:0] rgb_char,
    input  logic [2:0] rgb_mess,
    output logic [2:0] rgb
);

    logic [2:0] layer_rgb [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] present;
    logic [2:0] pix_d;

    assign layer_rgb[LAYER_BACK] = rgb_back;
    assign layer_rgb[LAYER_COIN] = rgb_coin;
    assign layer_rgb[LAYER_CHAR] = rgb_char;
    assign layer_rgb[LAYER_MESS] = rgb_mess;

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            present[i] = enables[i] & (|layer_rgb[i]);
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives pix_d and no latch is inferred.
        pix_d = 3'b000;
        if (video_on) begin
            // Walk from lowest to highest priority so the last hit wins.
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (present[i]) begin
                    pix_d = layer_rgb[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= 3'b000;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values, independent of block order.
            rgb <= pix_d;
        end
    end

endmodule

// File: rtl/display_sequencer.sv
//------------------------------------------------------------------------------
// display_sequencer
// Game-screen controller: a title/play/win/lose FSM selects which RGB layers
// reach the VGA pins through a registered priority compositor, counts coins,
// and times the WIN/LOSE message screens in frames (vsync rising edges).
//
// Optional feature macro: BLINK_EN
//   defined   - title message blinks in IDLE, BLINK_FRAMES ticks per half-period
//   undefined - title message is solid, no blink logic is built
//
// Ports:
//   clk, rst_n               pixel clock, async active-low reset
//   vsync                    VGA vsync (active-low pulse); rising edge = frame tick
//   video_on                 visible-area flag
//   start                    level, IDLE -> PLAY
//   coin_hit, hazard_hit     one-cycle game event pulses
//   r/g/b_back|char|coin|mess  layer pixels
//   r/g/b_buf                registered composited pixel
//   state                    current FSM state (IDLE=0 PLAY=1 WIN=2 LOSE=3)
//   coin_count               coins collected this game
//   msg_sel                  message ROM select (0 title, 1 win, 2 lose, 3 none)
//------------------------------------------------------------------------------
module display_sequencer
    import display_pkg::*;
#(
    parameter int COIN_GOAL    = 8,
    parameter int CNT_W        = 4,
    parameter int MSG_FRAMES   = 120,
    parameter int BLINK_FRAMES = 30,
    parameter int FRM_W        = 8
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    input  logic             video_on,
    input  logic             start,
    input  logic             coin_hit,
    input  logic             hazard_hit,
    input  logic             r_back,
    input  logic             g_back,
    input  logic             b_back,
    input  logic             r_char,
    input  logic             g_char,
    input  logic             b_char,
    input  logic             r_coin,
    input  logic             g_coin,
    input  logic             b_coin,
    input  logic             r_mess,
    input  logic             g_mess,
    input  logic             b_mess,
    output logic             r_buf,
    output logic             g_buf,
    output logic             b_buf,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] coin_count,
    output logic [1:0]       msg_sel
);

    // Parameter range checks at elaboration.
    if (COIN_GOAL < 1 || COIN_GOAL > (2**CNT_W) - 1) begin : g_bad_goal
        $error("COIN_GOAL out of range for CNT_W");
    end
    if (MSG_FRAMES < 1 || MSG_FRAMES > 2**FRM_W) begin : g_bad_msg
        $error("MSG_FRAMES out of range for FRM_W");
    end
    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 2**FRM_W) begin : g_bad_blink
        $error("BLINK_FRAMES out of range for FRM_W");
    end

    localparam logic [CNT_W-1:0] GOAL     = CNT_W'(COIN_GOAL);
    localparam logic [FRM_W-1:0] MSG_LAST = FRM_W'(MSG_FRAMES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   coin_q, coin_d;
    logic [FRM_W-1:0]   frame_q, frame_d;
    logic               vsync_d;
    logic               tick;
    logic               blink_on;
    logic [3:0]         enables;
    logic [2:0]         rgb_out;

    // Rising vsync marks the end of the sync pulse. vsync_d resets high so a
    // full low->high transition is needed after reset release.
    assign tick = vsync & ~vsync_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 1'b1;
        end else begin
            vsync_d <= vsync;
        end
    end

`ifdef BLINK_EN
    localparam logic [FRM_W-1:0] BLINK_LAST = FRM_W'(BLINK_FRAMES - 1);
    logic blink_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_on <= 1'b1;
        end else begin
            blink_on <= blink_d;
        end
    end
`else
    // Title message is solid without the blink feature.
    assign blink_on = 1'b1;
`endif

    //--------------------------------------------------------------------------
    // FSM state and counters
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            coin_q  <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            coin_q  <= coin_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d = state_q;
        coin_d  = coin_q;
        frame_d = frame_q;
`ifdef BLINK_EN
        blink_d = blink_on;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PLAY;
                    coin_d  = '0;
                    frame_d = '0;
                end
`ifdef BLINK_EN
                else if (tick) begin
                    if (frame_q == BLINK_LAST) begin
                        blink_d = ~blink_on;
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
`endif
            end
            ST_PLAY: begin
                // A hazard in the same cycle as a coin ends the game uncounted.
                if (hazard_hit) begin
                    state_d = ST_LOSE;
                    frame_d = '0;
                end else if (coin_hit) begin
                    if (coin_q != GOAL) begin
                        coin_d = coin_q + 1'b1;
                    end
                    if (coin_d == GOAL) begin
                        state_d = ST_WIN;
                        frame_d = '0;
                    end
                end
            end
            default: begin // ST_WIN, ST_LOSE: game inputs ignored
                if (tick) begin
                    if (frame_q == MSG_LAST) begin
                        state_d = ST_IDLE;
                        frame_d = '0;
`ifdef BLINK_EN
                        blink_d = 1'b1;
`endif
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Layer enables from the currently registered state
    //--------------------------------------------------------------------------
    always_comb begin
        enables = 4'b0000;
        enables[LAYER_BACK] = 1'b1;
        case (state_q)
            ST_IDLE: enables[LAYER_MESS] = blink_on;
            ST_PLAY: begin
                enables[LAYER_CHAR] = 1'b1;
                enables[LAYER_COIN] = 1'b1;
            end
            default: enables[LAYER_MESS] = 1'b1;
        endcase
    end

    layer_compositor u_compositor (
        .clk      (clk),
        .rst_n    (rst_n),
        .video_on (video_on),
        .enables  (enables),
        .rgb_back ({r_back, g_back, b_back}),
        .rgb_coin ({r_coin, g_coin, b_coin}),
        .rgb_char ({r_char, g_char, b_char}),
        .rgb_mess ({r_mess, g_mess, b_mess}),
        .rgb      (rgb_out)
    );

    assign {r_buf, g_buf, b_buf} = rgb_out;
    assign state      = state_q;
    assign coin_count = coin_q;
    assign msg_sel    = msg_for_state(state_q);

endmodule
